// File: rtl/channel_sequencer.sv
// Demux scan sequencer: walks selector 0..CHANNELS-1, holding enable high for
// dwell+1 cycles per channel with optional enable-low gaps between channels.
`ifndef CHANNEL_SEQUENCER_SV
`define CHANNEL_SEQUENCER_SV

module channel_sequencer #(
  parameter int CHANNELS    = 3,
  parameter int COUNT_WIDTH = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic                              stop,
  input  logic                              continuous,
  input  logic [COUNT_WIDTH-1:0]            dwell,
  input  logic [COUNT_WIDTH-1:0]            gap,
  output logic                              enable,
  output logic [$clog2(CHANNELS)-1:0]       selector,
  output logic                              busy,
  output logic                              done
);

  localparam int SELECTOR_WIDTH = $clog2(CHANNELS);
  localparam logic [SELECTOR_WIDTH-1:0] LAST_SEL = SELECTOR_WIDTH'(CHANNELS - 1);

  localparam logic [1:0] IDLE_ENC   = 2'd0;
  localparam logic [1:0] ACTIVE_ENC = 2'd1;
  localparam logic [1:0] GAP_ENC    = 2'd2;

  typedef enum logic [1:0] {
    IDLE   = IDLE_ENC,
    ACTIVE = ACTIVE_ENC,
    GAP    = GAP_ENC
  } state_t;

  state_t                    state, state_n;
  logic [COUNT_WIDTH-1:0]    cnt, cnt_n;
  logic [COUNT_WIDTH-1:0]    dwell_r, dwell_n;
  logic [COUNT_WIDTH-1:0]    gap_r, gap_n;
  logic                      cont_r, cont_n;
  logic [SELECTOR_WIDTH-1:0] sel_n;
  logic                      enable_n, busy_n, done_n;
  logic                      last;
  logic [SELECTOR_WIDTH-1:0] next_sel;

  // Explicit wrap keeps the selector inside range for non power-of-two counts
  assign last     = (selector == LAST_SEL);
  assign next_sel = last ? '0 : selector + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      dwell_r  <= '0;
      gap_r    <= '0;
      cont_r   <= 1'b0;
      selector <= '0;
      enable   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      dwell_r  <= dwell_n;
      gap_r    <= gap_n;
      cont_r   <= cont_n;
      selector <= sel_n;
      enable   <= enable_n;
      busy     <= busy_n;
      done     <= done_n;
    end
  end

  // One down-counter serves both dwell and gap; it reads 0 on the final cycle
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    dwell_n  = dwell_r;
    gap_n    = gap_r;
    cont_n   = cont_r;
    sel_n    = selector;
    enable_n = enable;
    busy_n   = busy;
    done_n   = 1'b0;
    case (state)
      IDLE: begin
        enable_n = 1'b0;
        busy_n   = 1'b0;
        if (start && !stop) begin
          dwell_n  = dwell;
          gap_n    = gap;
          cont_n   = continuous;
          cnt_n    = dwell;
          sel_n    = '0;
          enable_n = 1'b1;
          busy_n   = 1'b1;
          state_n  = ACTIVE;
        end
      end
      ACTIVE: begin
        if (stop) begin
          state_n  = IDLE;
          cnt_n    = '0;
          enable_n = 1'b0;
          busy_n   = 1'b0;
        end else if (cnt != '0) begin
          cnt_n = cnt - 1'b1;
        end else if (last && !cont_r) begin
          state_n  = IDLE;
          enable_n = 1'b0;
          busy_n   = 1'b0;
          done_n   = 1'b1;
        end else if (gap_r != '0) begin
          state_n  = GAP;
          enable_n = 1'b0;
          cnt_n    = gap_r - 1'b1;
        end else begin
          sel_n = next_sel;
          cnt_n = dwell_r;
        end
      end
      GAP: begin
        if (stop) begin
          state_n  = IDLE;
          cnt_n    = '0;
          enable_n = 1'b0;
          busy_n   = 1'b0;
        end else if (cnt != '0) begin
          cnt_n = cnt - 1'b1;
        end else begin
          state_n  = ACTIVE;
          enable_n = 1'b1;
          sel_n    = next_sel;
          cnt_n    = dwell_r;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

`endif

// File: tb/tb_channel_sequencer.sv
// Scoreboard bench: stimulus pushes per-cycle expectations, a monitor pops and
// compares them just after each rising edge (and right after an async reset).
module tb_channel_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0, stop = 1'b0, continuous = 1'b0;
  logic [7:0] dwell = 8'd0, gap = 8'd0;

  logic       en3, busy3, done3;
  logic [1:0] sel3;
  logic       en5, busy5, done5;
  logic [2:0] sel5;

  always #5 clk = ~clk;

  channel_sequencer #(.CHANNELS(3), .COUNT_WIDTH(8)) dut3 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .continuous(continuous),
    .dwell(dwell), .gap(gap), .enable(en3), .selector(sel3), .busy(busy3), .done(done3)
  );

  channel_sequencer #(.CHANNELS(5), .COUNT_WIDTH(8)) dut5 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .continuous(continuous),
    .dwell(dwell), .gap(gap), .enable(en5), .selector(sel5), .busy(busy5), .done(done5)
  );

  typedef struct {
    int         tnum;
    int         cyc;
    bit         use5;
    logic       en;
    logic [2:0] sel;
    logic       busy;
    logic       done;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   tnum  = 0;
  int   cyc   = 0;
  bit   use5  = 1'b0;

  task automatic push(input logic e, input int s, input logic b, input logic d);
    exp_t x;
    cyc    = cyc + 1;
    x.tnum = tnum;
    x.cyc  = cyc;
    x.use5 = use5;
    x.en   = e;
    x.sel  = 3'(s);
    x.busy = b;
    x.done = d;
    q.push_back(x);
  endtask

  // Drive inputs for the coming edge and expect the outputs that edge produces
  task automatic step(input logic st, input logic sp,
                      input logic e, input int s, input logic b, input logic d);
    @(negedge clk);
    start = st;
    stop  = sp;
    push(e, s, b, d);
  endtask

  task automatic new_test(input int n, input bit five);
    tnum = n;
    cyc  = 0;
    use5 = five;
  endtask

  // Single 3-channel pass, dwell=2 gap=1; operands scrambled after capture
  task automatic seq033(input logic xs);
    step(1, 0, 1, 0, 1, 0);
    step(xs, 0, 1, 0, 1, 0);
    dwell = 8'd7; gap = 8'd5; continuous = 1'b1;
    step(xs, 0, 1, 0, 1, 0);
    step(xs, 0, 0, 0, 1, 0);
    repeat (3) step(xs, 0, 1, 1, 1, 0);
    step(xs, 0, 0, 1, 1, 0);
    repeat (3) step(xs, 0, 1, 2, 1, 0);
    step(xs, 0, 0, 2, 0, 1);
    step(0, 0, 0, 2, 0, 0);
  endtask

  exp_t       mx;
  logic       a_en, a_busy, a_done;
  logic [2:0] a_sel;

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      #1;
      if (q.size() > 0) begin
        mx = q.pop_front();
        if (mx.use5) begin
          a_en = en5; a_sel = sel5; a_busy = busy5; a_done = done5;
        end else begin
          a_en = en3; a_sel = {1'b0, sel3}; a_busy = busy3; a_done = done3;
        end
        tests = tests + 1;
        if (a_en !== mx.en || a_sel !== mx.sel || a_busy !== mx.busy || a_done !== mx.done) begin
          fails = fails + 1;
          $display("FAIL t%0d_c%0d: got en=%b sel=%0d busy=%b done=%b, want en=%b sel=%0d busy=%b done=%b",
                   mx.tnum, mx.cyc, a_en, a_sel, a_busy, a_done, mx.en, mx.sel, mx.busy, mx.done);
        end
      end
    end
  end

  initial begin
    #100000;
    fails = fails + 1;
    $display("FAIL timeout: stimulus did not complete");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    // reset state
    #1;
    tests = tests + 1;
    if (en3 !== 1'b0 || sel3 !== 2'd0 || busy3 !== 1'b0 || done3 !== 1'b0 ||
        en5 !== 1'b0 || sel5 !== 3'd0 || busy5 !== 1'b0 || done5 !== 1'b0) begin
      fails = fails + 1;
      $display("FAIL reset_state: en3=%b sel3=%0d busy3=%b done3=%b en5=%b sel5=%0d busy5=%b done5=%b",
               en3, sel3, busy3, done3, en5, sel5, busy5, done5);
    end
    new_test(0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    rst = 1'b0;

    new_test(1, 0);
    dwell = 8'd2; gap = 8'd1; continuous = 1'b0;
    seq033(1'b0);

    // zero gap, dwell 0: enable continuous across channels
    new_test(2, 0);
    dwell = 8'd0; gap = 8'd0; continuous = 1'b0;
    step(1, 0, 1, 0, 1, 0);
    step(0, 0, 1, 1, 1, 0);
    step(0, 0, 1, 2, 1, 0);
    step(0, 0, 0, 2, 0, 1);
    step(0, 0, 0, 2, 0, 0);

    // start+stop in IDLE: stop wins, selector holds
    new_test(5, 0);
    step(1, 1, 0, 2, 0, 0);
    step(0, 0, 0, 2, 0, 0);

    // continuous wrap on 5 channels, dwell=1 gap=0
    new_test(3, 1);
    dwell = 8'd1; gap = 8'd0; continuous = 1'b1;
    step(1, 0, 1, 0, 1, 0);
    step(0, 0, 1, 0, 1, 0);
    step(0, 0, 1, 1, 1, 0); step(0, 0, 1, 1, 1, 0);
    step(0, 0, 1, 2, 1, 0); step(0, 0, 1, 2, 1, 0);
    step(0, 0, 1, 3, 1, 0); step(0, 0, 1, 3, 1, 0);
    step(0, 0, 1, 4, 1, 0); step(0, 0, 1, 4, 1, 0);
    step(0, 0, 1, 0, 1, 0); step(0, 0, 1, 0, 1, 0);
    step(0, 0, 1, 1, 1, 0); step(0, 0, 1, 1, 1, 0);
    step(0, 1, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0);

    // continuous on 3 channels with gap taken at the wrap
    new_test(4, 0);
    dwell = 8'd0; gap = 8'd1; continuous = 1'b1;
    step(1, 0, 1, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 1, 1, 1, 0);
    step(0, 0, 0, 1, 1, 0);
    step(0, 0, 1, 2, 1, 0);
    step(0, 0, 0, 2, 1, 0);
    step(0, 0, 1, 0, 1, 0);
    step(0, 1, 0, 0, 0, 0);

    // abort in cycle 6, restart in cycle 8
    new_test(6, 0);
    dwell = 8'd2; gap = 8'd1; continuous = 1'b0;
    step(1, 0, 1, 0, 1, 0);
    step(0, 0, 1, 0, 1, 0);
    step(0, 0, 1, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 1, 1, 1, 0);
    step(0, 0, 1, 1, 1, 0);
    step(0, 1, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    step(1, 0, 1, 0, 1, 0);
    step(0, 0, 1, 0, 1, 0);
    step(0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);

    // start held during busy must not disturb timing
    new_test(7, 0);
    dwell = 8'd2; gap = 8'd1; continuous = 1'b0;
    seq033(1'b1);

    // asynchronous reset mid-scan
    new_test(8, 0);
    dwell = 8'd2; gap = 8'd1; continuous = 1'b0;
    step(1, 0, 1, 0, 1, 0);
    step(0, 0, 1, 0, 1, 0);
    step(0, 0, 1, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 1, 1, 1, 0);
    @(negedge clk);
    #1;
    push(0, 0, 0, 0);
    rst = 1'b1;
    #1;
    tests = tests + 1;
    if (en3 !== 1'b0 || sel3 !== 2'd0 || busy3 !== 1'b0 || done3 !== 1'b0) begin
      fails = fails + 1;
      $display("FAIL async_reset: en=%b sel=%0d busy=%b done=%b", en3, sel3, busy3, done3);
    end
    #2;
    rst = 1'b0;
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(1, 0, 1, 0, 1, 0);
    step(0, 0, 1, 0, 1, 0);
    step(0, 1, 0, 0, 0, 0);

    @(negedge clk);
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
